// File: rtl/fetch_block_pkg.sv
// Shared types and constants for the Thumb instruction fetch stage.
package fetch_block_pkg;
  localparam int WORD          = 32;
  localparam int INSTR_W       = 16;
  localparam int THUMB_PC_STEP = 2;

  typedef logic [WORD-1:0]    word_t;
  typedef logic [INSTR_W-1:0] instruction;

  localparam instruction NOP_INSTRUCTION = 16'h0000;

  typedef enum logic {PIPELINE_RUN = 1'b0, STALL_PIPELINE = 1'b1} stall_pipeline_sig;

  typedef enum logic [1:0] {FETCH_REQ, FETCH_WAIT, FETCH_DROP} fetch_state_t;

  typedef struct packed {
    instruction instr;
    word_t      pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_block_queue.sv
// Circular FIFO of fetched {instruction, pc} pairs; 'reserve' holds back one
// slot for a response that is still in flight so it can never overflow.
module fetch_queue
  import fetch_block_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  instruction                 push_instr,
  input  word_t                      push_pc,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       reserve,
  output instruction                 head_instr,
  output word_t                      head_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W:0]       occupancy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count_q <= count_q + 1'b1;
      else if (pop && !push)
        count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only observable between push and pop.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= {push_instr, push_pc};
  end

  assign head_instr = mem[rd_ptr].instr;
  assign head_pc    = mem[rd_ptr].pc;
  assign count      = count_q;
  assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, reserve};
  assign full       = (occupancy >= (CNT_W+1)'(DEPTH));
endmodule

// File: rtl/fetch_block.sv
// Instruction fetch stage: PC sequencing, single-outstanding imem handshake,
// instruction queue and decode-facing output register. Optional macro
// FETCH_PERF_CNT_EN adds saturating stall/flush/memory-wait counters.
module fetch_block
  import fetch_block_pkg::*;
#(
  parameter int    BUF_DEPTH = 2,
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter int    PC_STEP   = THUMB_PC_STEP
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pipeline_ctrl_sig_i,
  input  logic              branch_taken_i,
  input  logic [WORD-1:0]   branch_target_i,
  output logic              imem_req_o,
  output logic [WORD-1:0]   imem_addr_o,
  input  logic              imem_ready_i,
  input  logic [15:0]       imem_rdata_i,
  output logic [15:0]       instruction_o,
  output logic [WORD-1:0]   program_counter_o,
  output logic              instr_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [WORD-1:0]   stall_cycles_o,
  output logic [WORD-1:0]   flush_count_o,
  output logic [WORD-1:0]   mem_wait_cycles_o
`endif
);
  fetch_state_t                  state;
  word_t                         fetch_pc;
  word_t                         aligned_target;
  logic                          stalled;
  logic                          accept;
  logic                          bypass;
  logic                          q_push;
  logic                          q_pop;
  logic                          q_empty;
  logic                          q_full;
  logic [$clog2(BUF_DEPTH):0]    q_count;
  instruction                    q_head_instr;
  word_t                         q_head_pc;

  assign stalled        = (stall_pipeline_sig'(pipeline_ctrl_sig_i) == STALL_PIPELINE);
  assign aligned_target = branch_target_i & ~word_t'(1);
  assign accept         = (state == FETCH_WAIT) && imem_ready_i && !branch_taken_i;
  assign q_empty        = (q_count == '0);
  // An empty queue with decode free lets the response skip the queue entirely.
  assign bypass         = accept && !stalled && q_empty;
  assign q_push         = accept && !bypass;
  assign q_pop          = !branch_taken_i && !stalled && !q_empty;

  fetch_queue #(.DEPTH(BUF_DEPTH)) u_queue (
    .clk        (clk_i),
    .reset      (reset_i),
    .push       (q_push),
    .push_instr (imem_rdata_i),
    .push_pc    (imem_addr_o),
    .pop        (q_pop),
    .flush      (branch_taken_i),
    .reserve    (state == FETCH_WAIT),
    .head_instr (q_head_instr),
    .head_pc    (q_head_pc),
    .count      (q_count),
    .full       (q_full)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= FETCH_REQ;
      fetch_pc    <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
    end else begin
      if (branch_taken_i)
        fetch_pc <= aligned_target;
      else if (accept)
        fetch_pc <= fetch_pc + word_t'(PC_STEP);

      case (state)
        FETCH_REQ: begin
          if (!branch_taken_i && !q_full) begin
            imem_req_o  <= 1'b1;
            imem_addr_o <= fetch_pc;
            state       <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (imem_ready_i) begin
            imem_req_o <= 1'b0;
            state      <= FETCH_REQ;
          end else if (branch_taken_i) begin
            state <= FETCH_DROP;
          end
        end
        FETCH_DROP: begin
          if (imem_ready_i) begin
            imem_req_o <= 1'b0;
            state      <= FETCH_REQ;
          end
        end
        default: begin
          imem_req_o <= 1'b0;
          state      <= FETCH_REQ;
        end
      endcase
    end
  end

  // Decode-facing register; program_counter_o is left as-is while invalid.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      instruction_o     <= NOP_INSTRUCTION;
      program_counter_o <= RESET_PC;
      instr_valid_o     <= 1'b0;
    end else if (branch_taken_i) begin
      instruction_o <= NOP_INSTRUCTION;
      instr_valid_o <= 1'b0;
    end else if (!stalled) begin
      if (!q_empty) begin
        instruction_o     <= q_head_instr;
        program_counter_o <= q_head_pc;
        instr_valid_o     <= 1'b1;
      end else if (bypass) begin
        instruction_o     <= imem_rdata_i;
        program_counter_o <= imem_addr_o;
        instr_valid_o     <= 1'b1;
      end else begin
        instruction_o <= NOP_INSTRUCTION;
        instr_valid_o <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cycles_o    <= '0;
      flush_count_o     <= '0;
      mem_wait_cycles_o <= '0;
    end else begin
      if (stalled && stall_cycles_o != '1)
        stall_cycles_o <= stall_cycles_o + 1'b1;
      if (branch_taken_i && flush_count_o != '1)
        flush_count_o <= flush_count_o + 1'b1;
      if ((state == FETCH_WAIT || state == FETCH_DROP) && !imem_ready_i &&
          mem_wait_cycles_o != '1)
        mem_wait_cycles_o <= mem_wait_cycles_o + 1'b1;
    end
  end
`endif
endmodule
